pwm_gen_multi: RTL and testbench
================================

// Module: pwm_gen_multi
// PURPOSE
//   Multi-channel PWM generator with its own period counter and per-channel mode selection.
//   Compare values and modes are double-buffered and become active only at the period boundary.
//   It sits below the register file: config writes come in one channel at a time and it drives
//   CH PWM pins. It replaces external-counter, single-channel PWM generation in new designs.
// PARAMETERS
//   CH  4   number of PWM channels (1..16)
//   CW  16  counter, period and compare width in bits
// PORTS
//   clk        in   1            system clock, all logic on rising edge
//   rst        in   1            asynchronous, active-high reset
//   pwm_en     in   1            global enable; low = stop, counter cleared, outputs low
//   period     in   CW           last count value of a period (counter runs 0..period)
//   cfg_wr     in   1            one-cycle write strobe into the shadow registers of cfg_ch
//   cfg_ch     in   max(1,$clog2(CH))  target channel; values >= CH are ignored
//   cfg_mode   in   2            00 left, 01 right, 10 range, 11 reserved (output low)
//   cfg_cmp1   in   CW           compare 1
//   cfg_cmp2   in   CW           compare 2 (range mode only)
//   count_val  out  CW           current counter value
//   period_end out  1            one-cycle pulse in the cycle count_val == active period while running
//   pwm_out    out  CH           registered PWM outputs
// BEHAVIOUR
//   Reset: count_val=0, period_end=0, pwm_out=0. All shadow and active mode/cmp1/cmp2 regs=0.
//     Active period reg=0. State=IDLE.
//   FSM: IDLE -> RUN on the first edge where pwm_en=1. RUN -> IDLE on any edge where pwm_en=0.
//   IDLE: count_val=0, pwm_out=0, period_end=0.
//     Active regs (period, mode, cmp1, cmp2) are loaded from the inputs/shadows every cycle,
//     so the first period after enable uses the latest values.
//   RUN counter: if count_val == active period, it wraps to 0, period_end=1 and an update
//     event fires. Otherwise it increments by 1.
//   Update event: active period <= period input; every channel's active regs <= shadow regs,
//     all on the same edge.
//   Active period = 0: counter stays 0, period_end pulses every cycle, pwm_out all low.
//   Config write: on cfg_wr=1 the shadow regs of cfg_ch take cfg_mode/cfg_cmp1/cfg_cmp2 at the edge.
//     A write that coincides with an update event does not reach the active regs that edge.
//     It takes effect at the next update event.
//   The period input is sampled only at update events (or in IDLE). Changing it mid-period
//     never truncates the current period.
//   Per channel, with c = count_val before the edge and the channel's active regs:
//     cmp1==0 or cmp1==cmp2 -> 0
//     left  (00): c <= cmp1
//     right (01): c >= cmp1
//     range (10): cmp1 <= c < cmp2 (cmp2 < cmp1 gives constant 0)
//     11: 0
//   pwm_out[i] registers that result: it shows the level for count value c one cycle after
//     count_val==c. Latency is 1 clk.
//   When pwm_en falls, pwm_out goes 0 on the same edge the counter clears.
//     No partial-period completion.
//   Compares are unsigned and CW bits wide. No arithmetic beyond the CW-bit increment.
//     The counter never exceeds the active period.
//   An asynchronous reset mid-period immediately clears all state. Shadow contents are lost.
// TESTING
//   1 Reset: CH=4, CW=16, assert rst mid-run -> pwm_out=0, count_val=0 with no clock edge needed.
//   2 Left mode: period=9, ch0 cmp1=3, enable -> pwm_out[0] high 4 of every 10 cycles
//     (c=0..3), delayed 1 clk; period_end every 10th cycle.
//   3 Right/range: ch1 right cmp1=7; ch2 range cmp1=2, cmp2=5 with period=9 ->
//     ch1 high for c=7..9, ch2 high for c=2..4; ch3 mode 11 stays low.
//   4 Double buffer: ch0 cmp1 3->6 written at c=5 -> current period still 4-high.
//     The next period is 7-high. A write exactly on the wrap cycle applies one period later.
//   5 Period change: period 9->4 written at c=2 -> current period ends at 9.
//     Following periods are 5 cycles long. period=0 -> outputs low, period_end constant 1.
//   6 Edges: cmp1=0, cmp1==cmp2, cfg_ch>=CH write (no effect), pwm_en drop mid-period ->
//     outputs low next edge, count_val=0; re-enable restarts at c=0.

Source files
------------

// File: rtl/pwm_gen_multi.sv
// ---------------------------------------------------------------------------
// pwm_gen_multi
//   Multi-channel PWM generator with an internal period counter. Each channel
//   selects left-aligned, right-aligned or range (window) mode. Mode, compare 1
//   and compare 2 are written one channel at a time into shadow registers. The
//   shadows, and the period input, are copied into the active registers only at
//   the period boundary, so a running period is never disturbed.
//
// Parameters
//   CH          number of PWM channels (1..16)
//   CW          counter / period / compare width in bits
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         asynchronous active-high reset
//   pwm_en      global enable; low stops the counter and forces outputs low
//   period      last count value of a period (counter runs 0..period)
//   cfg_wr      one-cycle write strobe into the shadow registers of cfg_ch
//   cfg_ch      target channel; values >= CH are ignored
//   cfg_mode    00 left, 01 right, 10 range, 11 reserved (output low)
//   cfg_cmp1    compare 1
//   cfg_cmp2    compare 2 (range mode only)
//   count_val   current counter value
//   period_end  high in the cycle count_val equals the active period while running
//   pwm_out     registered PWM outputs, one clock behind count_val
// ---------------------------------------------------------------------------
module pwm_gen_multi #(
    parameter int CH = 4,
    parameter int CW = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  pwm_en,
    input  logic [CW-1:0]                         period,
    input  logic                                  cfg_wr,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
    input  logic [1:0]                            cfg_mode,
    input  logic [CW-1:0]                         cfg_cmp1,
    input  logic [CW-1:0]                         cfg_cmp2,
    output logic [CW-1:0]                         count_val,
    output logic                                  period_end,
    output logic [CH-1:0]                         pwm_out
);

    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [1:0] MODE_LEFT  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_RANGE = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] active_period_reg;

    logic at_end;       // counter sits on the last value of the period
    logic load_active;  // copy shadows / period input into the active set
    logic drive_level;  // channel outputs follow their compare result this edge

    assign at_end = (count_reg == active_period_reg);

    // In IDLE the active set tracks the shadows every cycle so the first
    // period after enable already uses the newest configuration. While
    // running it is refreshed only on the wrap edge (the update event).
    assign load_active = (state_reg == IDLE) || at_end;

    // Outputs are forced low in IDLE, on the edge that leaves RUN, and while
    // the active period is zero (counter parked at 0, nothing to modulate).
    assign drive_level = (state_reg == RUN) && pwm_en && (active_period_reg != '0);

    assign count_val  = count_reg;
    assign period_end = (state_reg == RUN) && at_end;

    // -----------------------------------------------------------------------
    // Control FSM and period counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            count_reg         <= '0;
            active_period_reg <= '0;
        end else begin
            if (load_active) begin
                active_period_reg <= period;
            end
            case (state_reg)
                IDLE: begin
                    count_reg <= '0;
                    if (pwm_en) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (!pwm_en) begin
                        // Stop immediately; no completion of the partial period.
                        state_reg <= IDLE;
                        count_reg <= '0;
                    end else if (at_end) begin
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel shadow/active registers and compare logic
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [1:0]    shadow_mode_reg;
            logic [CW-1:0] shadow_cmp1_reg;
            logic [CW-1:0] shadow_cmp2_reg;
            logic [1:0]    active_mode_reg;
            logic [CW-1:0] active_cmp1_reg;
            logic [CW-1:0] active_cmp2_reg;
            logic          pwm_reg;
            logic          sel;
            logic          level;

            // Only indices 0..CH-1 exist, so an out-of-range cfg_ch never
            // matches any channel and the write is dropped.
            assign sel = cfg_wr && (cfg_ch == CHW'(gi));

            // A write on the wrap edge lands in the shadow while the active
            // set takes the old shadow value, so it applies one period later.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shadow_mode_reg <= '0;
                    shadow_cmp1_reg <= '0;
                    shadow_cmp2_reg <= '0;
                    active_mode_reg <= '0;
                    active_cmp1_reg <= '0;
                    active_cmp2_reg <= '0;
                end else begin
                    if (load_active) begin
                        active_mode_reg <= shadow_mode_reg;
                        active_cmp1_reg <= shadow_cmp1_reg;
                        active_cmp2_reg <= shadow_cmp2_reg;
                    end
                    if (sel) begin
                        shadow_mode_reg <= cfg_mode;
                        shadow_cmp1_reg <= cfg_cmp1;
                        shadow_cmp2_reg <= cfg_cmp2;
                    end
                end
            end

            // Level for the current count value. cmp1 == 0 and cmp1 == cmp2
            // both mean "off" regardless of mode.
            always_comb begin
                level = 1'b0;
                if ((active_cmp1_reg != '0) && (active_cmp1_reg != active_cmp2_reg)) begin
                    case (active_mode_reg)
                        MODE_LEFT:  level = (count_reg <= active_cmp1_reg);
                        MODE_RIGHT: level = (count_reg >= active_cmp1_reg);
                        MODE_RANGE: level = (count_reg >= active_cmp1_reg) &&
                                            (count_reg <  active_cmp2_reg);
                        default:    level = 1'b0;
                    endcase
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pwm_reg <= 1'b0;
                end else if (drive_level) begin
                    pwm_reg <= level;
                end else begin
                    pwm_reg <= 1'b0;
                end
            end

            assign pwm_out[gi] = pwm_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pwm_gen_multi.sv
// ---------------------------------------------------------------------------
// tb_pwm_gen_multi
//   Scoreboard bench. The stimulus process drives directed configurations and
//   pushes the expected count/period_end/pwm for every clock into a queue; a
//   separate monitor pops and compares on the falling edge (or on demand for
//   the asynchronous reset check). Each channel's expected high window
//   [lo, hi] is worked out by hand from its mode and compares.
//   A second instance (CH=3, CW=8) only ever receives writes to cfg_ch=3,
//   which does not exist, so its outputs must stay low.
// ---------------------------------------------------------------------------
module tb_pwm_gen_multi;

    localparam int CH = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          pwm_en;
    logic [CW-1:0] period;
    logic          cfg_wr;
    logic [1:0]    cfg_ch;
    logic [1:0]    cfg_mode;
    logic [CW-1:0] cfg_cmp1;
    logic [CW-1:0] cfg_cmp2;
    logic [CW-1:0] count_val;
    logic          period_end;
    logic [CH-1:0] pwm_out;

    logic [1:0]    cfg_ch3;
    logic [7:0]    count3;
    logic          pe3;
    logic [2:0]    pwm3;

    assign cfg_ch3 = 2'd3;

    always #5 clk = ~clk;

    pwm_gen_multi #(.CH(CH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .pwm_en(pwm_en), .period(period),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_cmp1(cfg_cmp1), .cfg_cmp2(cfg_cmp2),
        .count_val(count_val), .period_end(period_end), .pwm_out(pwm_out)
    );

    pwm_gen_multi #(.CH(3), .CW(8)) dut3 (
        .clk(clk), .rst(rst), .pwm_en(pwm_en), .period(period[7:0]),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch3), .cfg_mode(cfg_mode),
        .cfg_cmp1(cfg_cmp1[7:0]), .cfg_cmp2(cfg_cmp2[7:0]),
        .count_val(count3), .period_end(pe3), .pwm_out(pwm3)
    );

    typedef struct {
        string       tag;
        logic [15:0] cnt;
        logic        pe;
        logic [3:0]  pwm;
    } exp_t;

    exp_t  sb[$];
    event  ev_sample;
    int    checks = 0;
    int    failures = 0;
    string tag = "init";

    // Expected-behaviour state (spec level: windows swap at the wrap)
    int cur_c;
    bit running;
    int per_act;
    int lo_act[CH], hi_act[CH], lo_nxt[CH], hi_nxt[CH];
    bit pend;
    int pend_ch, pend_lo, pend_hi;

    // ---------------------------- monitor ---------------------------------
    always begin
        @(negedge clk or ev_sample);
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (count_val !== e.cnt || period_end !== e.pe || pwm_out !== e.pwm ||
                count3 !== e.cnt[7:0] || pe3 !== e.pe || pwm3 !== 3'b000) begin
                failures++;
                $display("FAIL %s: got count_val=%0d period_end=%0b pwm_out=%b dut3 count=%0d pe=%0b pwm=%b; required count_val=%0d period_end=%0b pwm_out=%b dut3 pwm=000",
                         e.tag, count_val, period_end, pwm_out, count3, pe3, pwm3,
                         e.cnt, e.pe, e.pwm);
            end
        end
    end

    // ---------------------------- stimulus --------------------------------
    task automatic clear_nxt();
        for (int i = 0; i < CH; i++) begin
            lo_nxt[i] = 1;
            hi_nxt[i] = 0;
        end
    endtask

    task automatic step();
        exp_t       e;
        logic [3:0] pw;
        int         prev;
        @(posedge clk);
        #1;
        pw = '0;
        if (rst) begin
            running = 0;
            cur_c   = 0;
            per_act = 0;
            clear_nxt();
            pend    = 0;
        end else if (!pwm_en) begin
            running = 0;
            cur_c   = 0;
        end else if (!running) begin
            running = 1;
            cur_c   = 0;
            per_act = int'(period);
            for (int i = 0; i < CH; i++) begin
                lo_act[i] = lo_nxt[i];
                hi_act[i] = hi_nxt[i];
            end
        end else begin
            prev = cur_c;
            for (int i = 0; i < CH; i++) begin
                pw[i] = (per_act != 0 && prev >= lo_act[i] && prev <= hi_act[i]) ? 1'b1 : 1'b0;
            end
            if (prev == per_act) begin
                cur_c   = 0;
                per_act = int'(period);
                for (int i = 0; i < CH; i++) begin
                    lo_act[i] = lo_nxt[i];
                    hi_act[i] = hi_nxt[i];
                end
            end else begin
                cur_c = prev + 1;
            end
        end
        if (pend) begin
            lo_nxt[pend_ch] = pend_lo;
            hi_nxt[pend_ch] = pend_hi;
            pend = 0;
        end
        e.tag = tag;
        e.cnt = 16'(cur_c);
        e.pe  = (running && cur_c == per_act) ? 1'b1 : 1'b0;
        e.pwm = pw;
        sb.push_back(e);
    endtask

    // One-cycle config write; lo/hi is the hand-derived high window.
    task automatic cfg(input int ch, input logic [1:0] mode, input int c1, input int c2,
                       input int lo, input int hi);
        cfg_ch   = 2'(ch);
        cfg_mode = mode;
        cfg_cmp1 = 16'(c1);
        cfg_cmp2 = 16'(c2);
        cfg_wr   = 1'b1;
        pend     = 1;
        pend_ch  = ch;
        pend_lo  = lo;
        pend_hi  = hi;
        step();
        cfg_wr   = 1'b0;
    endtask

    task automatic wait_c(input int n);
        for (int i = 0; i < 64 && cur_c != n; i++) step();
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; pwm_en = 1'b0; period = '0; cfg_wr = 1'b0;
        cfg_ch = '0; cfg_mode = '0; cfg_cmp1 = '0; cfg_cmp2 = '0;
        running = 0; cur_c = 0; per_act = 0; pend = 0;
        clear_nxt();
        for (int i = 0; i < CH; i++) begin
            lo_act[i] = 1;
            hi_act[i] = 0;
        end

        tag = "reset";
        repeat (3) step();
        rst = 1'b0;
        tag = "idle";
        step();

        // Left / right / range / reserved with period 9
        period = 16'd9;
        tag = "cfg_idle";
        cfg(0, 2'b00, 3, 0, 0, 3);
        cfg(1, 2'b01, 7, 0, 7, 65535);
        cfg(2, 2'b10, 2, 5, 2, 4);
        cfg(3, 2'b11, 1, 8, 1, 0);
        step();
        tag = "run_modes";
        pwm_en = 1'b1;
        repeat (31) step();

        // Double buffering: mid-period write, then write on the wrap edge
        tag = "dbuf_mid";
        wait_c(5);
        cfg(0, 2'b00, 6, 0, 0, 6);
        wait_c(9);
        tag = "dbuf_wrap";
        cfg(0, 2'b00, 2, 0, 0, 2);
        repeat (20) step();

        // Period change mid-period, then period 0
        tag = "period_chg";
        wait_c(2);
        period = 16'd4;
        repeat (22) step();
        tag = "period_zero";
        period = 16'd0;
        repeat (12) step();

        // Edge cases: all of these must produce a constant low output
        tag = "edge_cfg";
        period = 16'd9;
        cfg(0, 2'b00, 0, 0, 1, 0);
        cfg(1, 2'b01, 0, 0, 1, 0);
        cfg(2, 2'b10, 4, 4, 1, 0);
        cfg(3, 2'b10, 6, 3, 1, 0);
        repeat (12) step();

        // Enable drop mid-period and restart
        tag = "pre_drop";
        cfg(0, 2'b00, 5, 0, 0, 5);
        wait_c(9);
        step();
        wait_c(4);
        tag = "en_drop";
        pwm_en = 1'b0;
        repeat (2) step();
        tag = "re_enable";
        pwm_en = 1'b1;
        repeat (15) step();

        // Asynchronous reset mid-run, checked before any further clock edge
        tag = "pre_rst";
        wait_c(6);
        #5;
        rst = 1'b1;
        pwm_en = 1'b0;
        running = 0; cur_c = 0; per_act = 0; pend = 0;
        clear_nxt();
        e.tag = "async_rst"; e.cnt = '0; e.pe = 1'b0; e.pwm = '0;
        sb.push_back(e);
        #1;
        ->ev_sample;
        tag = "rst_hold";
        repeat (2) step();
        rst = 1'b0;

        // Shadows were lost: enabled again with no writes, outputs stay low
        tag = "post_rst";
        period = 16'd9;
        pwm_en = 1'b1;
        repeat (12) step();

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d entries left in scoreboard, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
